// File: rtl/i2c_target_stretch.sv
// ============================================================================
// Module   : i2c_target_stretch
// Brief    : I2C write-target bit engine; ACKs its address and stretches SCL
//            after every received byte until the consumer takes it.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_target_stretch #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_hold,
    output logic       sda_pull,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       addressed,
    output logic       stop_pulse
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_DATA     = 3'd3,
        S_STRETCH  = 3'd4,
        S_DATA_ACK = 3'd5,
        S_IGNORE   = 3'd6
    } state_t;

    logic       r_scl_meta, r_scl_sync, r_scl_prev;
    logic       r_sda_meta, r_sda_sync, r_sda_prev;
    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_ack_wait;

    logic       w_start, w_stop, w_rise, w_fall;
    logic [7:0] w_shifted;
    logic       w_addr_ok;

    // Flops reset to 1 so an idle bus produces no spurious edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= scl_in;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= sda_in;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    assign w_start   = r_scl_prev & r_scl_sync & r_sda_prev & ~r_sda_sync;
    assign w_stop    = r_scl_prev & r_scl_sync & ~r_sda_prev & r_sda_sync;
    assign w_rise    = ~r_scl_prev & r_scl_sync;
    assign w_fall    = r_scl_prev & ~r_scl_sync;
    assign w_shifted = {r_shift[6:0], r_sda_sync};
    assign w_addr_ok = (w_shifted[7:1] == ADDR) && !w_shifted[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
            r_ack_wait <= 1'b0;
            scl_hold   <= 1'b0;
            sda_pull   <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            addressed  <= 1'b0;
            stop_pulse <= 1'b0;
        end else begin
            stop_pulse <= 1'b0;
            // The handshake retires the byte in any state, even after STOP.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (w_stop) begin
                r_state    <= S_IDLE;
                r_ack_wait <= 1'b0;
                scl_hold   <= 1'b0;
                sda_pull   <= 1'b0;
                addressed  <= 1'b0;
                stop_pulse <= 1'b1;
            end else if (w_start) begin
                r_state    <= S_ADDR;
                r_bit_cnt  <= 4'd0;
                r_ack_wait <= 1'b0;
                scl_hold   <= 1'b0;
                sda_pull   <= 1'b0;
                addressed  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                    end
                    S_ADDR: begin
                        if (w_rise && r_bit_cnt < 4'd8) begin
                            r_shift   <= w_shifted;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7 && !w_addr_ok) begin
                                r_state <= S_IGNORE;
                            end
                        end else if (w_fall && r_bit_cnt == 4'd8) begin
                            sda_pull  <= 1'b1;
                            addressed <= 1'b1;
                            r_state   <= S_ADDR_ACK;
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_fall) begin
                            sda_pull  <= 1'b0;
                            r_bit_cnt <= 4'd0;
                            r_state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_rise && r_bit_cnt < 4'd8) begin
                            r_shift   <= w_shifted;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_fall && r_bit_cnt == 4'd8) begin
                            rx_data  <= r_shift;
                            rx_valid <= 1'b1;
                            scl_hold <= 1'b1;
                            r_state  <= S_STRETCH;
                        end
                    end
                    S_STRETCH: begin
                        // ACK is set up one cycle before SCL is let go.
                        if (r_ack_wait) begin
                            scl_hold   <= 1'b0;
                            r_ack_wait <= 1'b0;
                            r_state    <= S_DATA_ACK;
                        end else if (rx_valid && rx_ready) begin
                            sda_pull   <= 1'b1;
                            r_ack_wait <= 1'b1;
                        end
                    end
                    S_DATA_ACK: begin
                        if (w_fall) begin
                            sda_pull  <= 1'b0;
                            r_bit_cnt <= 4'd0;
                            r_state   <= S_DATA;
                        end
                    end
                    S_IGNORE: begin
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_stretch.sv
// ============================================================================
// Module   : tb_i2c_target_stretch
// Brief    : Directed bench: wired-AND I2C host model driving the target.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_target_stretch;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       host_scl = 1'b1;
    logic       host_sda = 1'b1;
    logic       ignore_hold = 1'b0;
    logic       rx_ready = 1'b0;
    logic       scl_hold, sda_pull, rx_valid, addressed, stop_pulse;
    logic [7:0] rx_data;
    logic       scl_wire, sda_wire;

    int errors = 0;
    int checks = 0;
    int pull_cnt = 0, stop_cnt = 0, valid_cycles = 0;
    int hold_run = 0, last_hold = 0;
    logic pull_at_release = 1'b0;
    logic consumer_en = 1'b0;
    int ready_delay = 0;
    int rdy_cnt = 0;
    logic [7:0] rx_log[$];

    assign scl_wire = host_scl & (ignore_hold | ~scl_hold);
    assign sda_wire = host_sda & ~sda_pull;

    always #5 clk = ~clk;

    i2c_target_stretch #(.ADDR(7'h50)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_wire),
        .sda_in    (sda_wire),
        .scl_hold  (scl_hold),
        .sda_pull  (sda_pull),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .addressed (addressed),
        .stop_pulse(stop_pulse)
    );

    // Monitors first, then the consumer, in one block to keep ordering fixed.
    always @(negedge clk) begin
        if (sda_pull) pull_cnt++;
        if (stop_pulse) stop_cnt++;
        if (rx_valid) valid_cycles++;
        if (scl_hold) begin
            hold_run++;
        end else if (hold_run != 0) begin
            last_hold = hold_run;
            hold_run = 0;
            pull_at_release = sda_pull;
        end
        if (!consumer_en) begin
            rx_ready = 1'b0;
            rdy_cnt = 0;
        end else if (rx_valid) begin
            rdy_cnt++;
            if (rdy_cnt >= ready_delay) rx_ready = 1'b1;
        end else begin
            rx_ready = (ready_delay == 0);
            rdy_cnt = 0;
        end
    end

    always @(posedge clk) begin
        if (rst && rx_valid && rx_ready) rx_log.push_back(rx_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_scl_high();
        for (int i = 0; i < 1000 && !scl_wire; i++) @(negedge clk);
        chk("scl_released", scl_wire, 1);
    endtask

    task automatic bus_start();
        host_sda = 1'b0;
        wait_cyc(H);
        host_scl = 1'b0;
    endtask

    task automatic bus_rep_start();
        wait_cyc(H / 2);
        host_sda = 1'b1;
        wait_cyc(H / 2);
        host_scl = 1'b1;
        wait_scl_high();
        wait_cyc(H / 2);
        host_sda = 1'b0;
        wait_cyc(H / 2);
        host_scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_cyc(H / 2);
        host_sda = 1'b0;
        wait_cyc(H / 2);
        host_scl = 1'b1;
        wait_scl_high();
        wait_cyc(H / 2);
        host_sda = 1'b1;
        wait_cyc(H);
    endtask

    task automatic send_bit(input logic b);
        wait_cyc(H / 2);
        host_sda = b;
        wait_cyc(H / 2);
        host_scl = 1'b1;
        wait_scl_high();
        wait_cyc(H);
        host_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic ack_clock(output logic a);
        wait_cyc(H / 2);
        host_sda = 1'b1;
        wait_cyc(H / 2);
        host_scl = 1'b1;
        wait_scl_high();
        wait_cyc(H / 2);
        a = sda_wire;
        wait_cyc(H / 2);
        host_scl = 1'b0;
    endtask

    initial begin
        logic a;
        int   n0;

        // Reset state
        wait_cyc(3);
        chk("rst_scl_hold", scl_hold, 0);
        chk("rst_sda_pull", sda_pull, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_addressed", addressed, 0);
        chk("rst_stop_pulse", stop_pulse, 0);
        rst = 1'b1;
        wait_cyc(4);

        // Write 0x50 / 0xA5, consumer always ready
        consumer_en = 1'b1;
        ready_delay = 0;
        bus_start();
        send_byte(8'hA0);
        ack_clock(a);
        chk("t1_addr_ack", a, 0);
        chk("t1_addressed", addressed, 1);
        valid_cycles = 0;
        send_byte(8'hA5);
        ack_clock(a);
        chk("t1_data_ack", a, 0);
        chk("t1_hold_len", last_hold, 2);
        chk("t1_ack_before_release", pull_at_release, 1);
        chk("t1_valid_cycles", valid_cycles, 1);
        chk("t1_log_size", rx_log.size(), 1);
        chk("t1_byte", rx_log[0], 8'hA5);
        stop_cnt = 0;
        bus_stop();
        chk("t1_stop_pulse", stop_cnt, 1);
        chk("t1_addressed_clr", addressed, 0);

        // Slow consumer: 100 cycles not ready, two back-to-back bytes
        ready_delay = 100;
        bus_start();
        send_byte(8'hA0);
        ack_clock(a);
        chk("t2_addr_ack", a, 0);
        send_byte(8'h01);
        ack_clock(a);
        chk("t2_ack1", a, 0);
        chk("t2_hold1", last_hold, 101);
        chk("t2_ack_before_release", pull_at_release, 1);
        send_byte(8'hFF);
        ack_clock(a);
        chk("t2_ack2", a, 0);
        chk("t2_hold2", last_hold, 101);
        chk("t2_log_size", rx_log.size(), 3);
        chk("t2_byte1", rx_log[1], 8'h01);
        chk("t2_byte2", rx_log[2], 8'hFF);
        bus_stop();
        ready_delay = 0;

        // Wrong address, then right address with read bit
        pull_cnt = 0;
        valid_cycles = 0;
        bus_start();
        send_byte(8'hA2);
        ack_clock(a);
        chk("t3_mismatch_nack", a, 1);
        send_byte(8'h33);
        ack_clock(a);
        chk("t3_ignore_nack", a, 1);
        chk("t3_addressed", addressed, 0);
        bus_stop();
        bus_start();
        send_byte(8'hA1);
        ack_clock(a);
        chk("t3_read_nack", a, 1);
        chk("t3_read_addressed", addressed, 0);
        bus_stop();
        chk("t3_no_pull", pull_cnt, 0);
        chk("t3_no_valid", valid_cycles, 0);

        // Repeated START mid-byte discards partial data
        n0 = rx_log.size();
        bus_start();
        send_byte(8'hA0);
        ack_clock(a);
        chk("t4_addr_ack", a, 0);
        valid_cycles = 0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        bus_rep_start();
        chk("t4_addressed_clr", addressed, 0);
        chk("t4_no_partial", valid_cycles, 0);
        send_byte(8'hA0);
        ack_clock(a);
        chk("t4_readdr_ack", a, 0);
        send_byte(8'h3C);
        ack_clock(a);
        chk("t4_data_ack", a, 0);
        chk("t4_log_size", rx_log.size(), n0 + 1);
        chk("t4_byte", rx_log[n0], 8'h3C);
        bus_stop();

        // STOP while a byte is still pending (host ignores the stretch)
        consumer_en = 1'b0;
        ignore_hold = 1'b1;
        n0 = rx_log.size();
        bus_start();
        send_byte(8'hA0);
        ack_clock(a);
        chk("t5_addr_ack", a, 0);
        send_byte(8'h5A);
        wait_cyc(6);
        chk("t5_stretching", scl_hold, 1);
        chk("t5_valid", rx_valid, 1);
        chk("t5_addressed", addressed, 1);
        stop_cnt = 0;
        bus_stop();
        chk("t5_stop_pulse", stop_cnt, 1);
        chk("t5_addressed_clr", addressed, 0);
        chk("t5_hold_released", scl_hold, 0);
        chk("t5_valid_kept", rx_valid, 1);
        chk("t5_data_kept", rx_data, 8'h5A);
        ignore_hold = 1'b0;
        consumer_en = 1'b1;
        wait_cyc(4);
        chk("t5_valid_consumed", rx_valid, 0);
        chk("t5_log_byte", rx_log[n0], 8'h5A);

        // Asynchronous reset during a stretch
        consumer_en = 1'b0;
        bus_start();
        send_byte(8'hA0);
        ack_clock(a);
        chk("t6_addr_ack", a, 0);
        send_byte(8'h77);
        wait_cyc(6);
        chk("t6_stretching", scl_hold, 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_scl_hold", scl_hold, 0);
        chk("t6_rst_sda_pull", sda_pull, 0);
        chk("t6_rst_valid", rx_valid, 0);
        chk("t6_rst_addressed", addressed, 0);
        wait_cyc(3);
        rst = 1'b1;
        consumer_en = 1'b1;
        wait_cyc(H);
        host_scl = 1'b1;
        wait_cyc(H);
        host_scl = 1'b0;
        pull_cnt = 0;
        send_byte(8'hA0);
        ack_clock(a);
        chk("t6_no_start_nack", a, 1);
        chk("t6_no_start_pull", pull_cnt, 0);
        bus_stop();
        n0 = rx_log.size();
        bus_start();
        send_byte(8'hA0);
        ack_clock(a);
        chk("t6_after_ack", a, 0);
        send_byte(8'hC3);
        ack_clock(a);
        chk("t6_data_ack", a, 0);
        chk("t6_byte", rx_log[n0], 8'hC3);
        bus_stop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
